// File: rtl/fifo_pkg.sv
// Shared constants and types for the FWFT byte FIFO.
// Imported by the output buffer and the FIFO top.
package fifo_pkg;

   localparam int FIFO_DEPTH = 1024;
   localparam int LEVEL_W    = 11;

   // Output buffer occupancy, 0..2
   typedef logic [1:0] bcnt_t;

   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_POP  = 2'b01,
      OP_CAP  = 2'b10,
      OP_BOTH = 2'b11
   } buf_op_e;

   function automatic logic [LEVEL_W-1:0] level_sum(
      input logic [LEVEL_W-1:0] ram_cnt,
      input logic               inflight,
      input bcnt_t              bcnt
   );
      return ram_cnt + LEVEL_W'(inflight) + LEVEL_W'(bcnt);
   endfunction

endpackage

// File: rtl/drm_8x1024.sv
// Simple dual-port 8x1024 RAM macro model.
// Registered read with 1-cycle latency, no extra output stage.
module drm_8x1024 (
   input  logic       wr_clk,
   input  logic       wr_rst,
   input  logic       wr_en,
   input  logic [9:0] wr_addr,
   input  logic       wr_byte_en,
   input  logic [7:0] wr_data,
   input  logic       rd_clk,
   input  logic       rd_rst,
   input  logic       rd_en,
   input  logic [9:0] rd_addr,
   output logic [7:0] rd_data
);

   logic [7:0] r_mem [0:1023];
   logic [7:0] r_rd_data;

   always_ff @(posedge wr_clk) begin
      if (!wr_rst && wr_en && wr_byte_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         r_rd_data <= '0;
      end else if (rd_en) begin
         r_rd_data <= r_mem[rd_addr];
      end
   end

   assign rd_data = r_rd_data;

endmodule

// File: rtl/fwft_out_buf.sv
// Two-entry FWFT output buffer: captures RAM read data,
// presents the head, shifts the tail forward on pop.
module fwft_out_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  i_clr,
   input  logic                  i_cap,
   input  logic [DATA_WIDTH-1:0] i_cap_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_head,
   output logic                  o_valid,
   output logic [1:0]            o_count,
   output logic [1:0]            o_count_nxt
);

   logic [DATA_WIDTH-1:0] r_head;
   logic [DATA_WIDTH-1:0] r_tail;
   bcnt_t                 r_cnt;

   logic [DATA_WIDTH-1:0] w_head_nxt;
   logic [DATA_WIDTH-1:0] w_tail_nxt;
   bcnt_t                 w_cnt_nxt;
   buf_op_e               w_op;

   always_comb begin
      w_op       = buf_op_e'({i_cap, i_pop});
      w_head_nxt = r_head;
      w_tail_nxt = r_tail;
      w_cnt_nxt  = r_cnt;
      unique case (w_op)
         OP_IDLE: begin
         end
         OP_POP: begin
            w_head_nxt = r_tail;
            w_cnt_nxt  = r_cnt - 2'd1;
         end
         OP_CAP: begin
            if (r_cnt == 2'd0) begin
               w_head_nxt = i_cap_data;
            end else begin
               w_tail_nxt = i_cap_data;
            end
            w_cnt_nxt = r_cnt + 2'd1;
         end
         OP_BOTH: begin
            // Capture lands where the popped slot frees up
            if (r_cnt == 2'd1) begin
               w_head_nxt = i_cap_data;
            end else begin
               w_head_nxt = r_tail;
               w_tail_nxt = i_cap_data;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_clr) begin
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
      end else begin
         r_head <= w_head_nxt;
         r_tail <= w_tail_nxt;
         r_cnt  <= w_cnt_nxt;
      end
   end

   assign o_head      = r_head;
   assign o_valid     = (r_cnt != 2'd0);
   assign o_count     = r_cnt;
   assign o_count_nxt = i_clr ? 2'd0 : w_cnt_nxt;

endmodule

// File: rtl/byte_fifo_fwft.sv
// First-word-fall-through byte FIFO around the drm_8x1024 RAM,
// with a 2-entry output buffer hiding the RAM read latency.
module byte_fifo_fwft
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int AFULL_TH   = 1000,
   parameter int AEMPTY_TH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [10:0]           level,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow_err
);

   localparam int CNT_W = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CNT_W-1:0]      r_ram_count;
   logic                  r_inflight;
   logic                  r_full;
   logic                  r_afull;
   logic                  r_aempty;
   logic                  r_ovf;

   logic                  w_clr;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_rd_issue;
   logic [2:0]            w_pending;
   logic [CNT_W-1:0]      w_ram_count_nxt;
   logic [LEVEL_W-1:0]    w_level_nxt;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic [DATA_WIDTH-1:0] w_head;
   logic                  w_buf_valid;
   logic [1:0]            w_buf_cnt;
   logic [1:0]            w_buf_cnt_nxt;

   assign w_clr  = rst | flush;
   assign w_push = in_valid & ~r_full & ~w_clr;
   assign w_pop  = w_buf_valid & out_ready;

   // Bytes that will sit in the buffer after this edge
   assign w_pending = {1'b0, w_buf_cnt}
                    + {2'b00, r_inflight}
                    - {2'b00, w_pop};

   assign w_rd_issue = (r_ram_count != '0)
                     & (w_pending < 3'd2)
                     & ~w_clr;

   assign w_ram_count_nxt = r_ram_count
                          + CNT_W'(w_push)
                          - CNT_W'(w_rd_issue);

   assign w_level_nxt = level_sum(LEVEL_W'(w_ram_count_nxt),
                                  w_rd_issue, w_buf_cnt_nxt);

   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_ram_count <= '0;
         r_inflight  <= 1'b0;
         r_full      <= 1'b0;
         r_afull     <= 1'b0;
         r_aempty    <= 1'b1;
         r_ovf       <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
         end
         if (w_rd_issue) begin
            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
         end
         r_ram_count <= w_ram_count_nxt;
         r_inflight  <= w_rd_issue;
         r_full      <= (w_ram_count_nxt == CNT_W'(FIFO_DEPTH));
         r_afull     <= (w_level_nxt >= LEVEL_W'(AFULL_TH));
         r_aempty    <= (w_level_nxt <= LEVEL_W'(AEMPTY_TH));
         if (in_valid && r_full) begin
            r_ovf <= 1'b1;
         end
      end
   end

   drm_8x1024 u_ram (
      .wr_clk     (clk),
      .wr_rst     (rst),
      .wr_en      (w_push),
      .wr_addr    (r_wr_ptr),
      .wr_byte_en (1'b1),
      .wr_data    (in_data),
      .rd_clk     (clk),
      .rd_rst     (rst),
      .rd_en      (w_rd_issue),
      .rd_addr    (r_rd_ptr),
      .rd_data    (w_rd_data)
   );

   fwft_out_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_buf (
      .clk         (clk),
      .i_clr       (w_clr),
      .i_cap       (r_inflight),
      .i_cap_data  (w_rd_data),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_valid     (w_buf_valid),
      .o_count     (w_buf_cnt),
      .o_count_nxt (w_buf_cnt_nxt)
   );

   assign in_ready     = ~r_full;
   assign out_data     = w_head;
   assign out_valid    = w_buf_valid;
   assign level        = level_sum(LEVEL_W'(r_ram_count),
                                   r_inflight, w_buf_cnt);
   assign almost_full  = r_afull;
   assign almost_empty = r_aempty;
   assign overflow_err = r_ovf;

endmodule

// File: tb/tb_byte_fifo_fwft.sv
// Self-checking bench for byte_fifo_fwft against a queue model
// where a byte is visible once it is the oldest and two edges old.
module tb_byte_fifo_fwft;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        flush     = 1'b0;
   logic [7:0]  in_data   = 8'h00;
   logic        in_valid  = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic [10:0] level;
   logic        almost_full;
   logic        almost_empty;
   logic        overflow_err;

   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [7:0]  q[$];
   int          qt[$];
   bit          m_ovf = 1'b0;
   bit          last_push;
   bit          last_pop;

   always #5 clk = ~clk;

   byte_fifo_fwft dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .level        (level),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow_err (overflow_err)
   );

   function automatic bit m_valid();
      return (q.size() > 0) && (cyc - qt[0] >= 2);
   endfunction

   function automatic logic [10:0] m_level();
      return 11'(q.size());
   endfunction

   task automatic tick(input bit v, input logic [7:0] d,
                       input bit r, input bit fl);
      bit rdy;
      bit pop;
      bit push;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = fl;
      rdy  = (q.size() < 1026);
      pop  = m_valid() & r;
      push = v & rdy & !fl & !rst;
      @(posedge clk);
      cyc++;
      last_push = push;
      last_pop  = pop;
      if (fl || rst) begin
         q.delete();
         qt.delete();
         m_ovf = 1'b0;
      end else begin
         if (v && !rdy) m_ovf = 1'b1;
         if (pop) begin
            void'(q.pop_front());
            void'(qt.pop_front());
         end
         if (push) begin
            q.push_back(d);
            qt.push_back(cyc);
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      tick(1'b1, 8'h5A, 1'b1, 1'b0);
      rst = 1'b0;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++;
         $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_chk++; if (out_valid !== 1'b0) begin n_fail++;
         $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_chk++; if (out_data !== 8'h00) begin n_fail++;
         $display("FAIL reset_out_data got %h want 00", out_data); end
      n_chk++; if (level !== 11'd0) begin n_fail++;
         $display("FAIL reset_level got %0d want 0", level); end
      n_chk++; if (almost_full !== 1'b0) begin n_fail++;
         $display("FAIL reset_afull got %b want 0", almost_full); end
      n_chk++; if (almost_empty !== 1'b1) begin n_fail++;
         $display("FAIL reset_aempty got %b want 1", almost_empty); end
      n_chk++; if (overflow_err !== 1'b0) begin n_fail++;
         $display("FAIL reset_ovf got %b want 0", overflow_err); end
   endtask

   task automatic test_single();
      tick(1'b1, 8'hA5, 1'b0, 1'b0);
      n_chk++; if (level !== 11'd1 || out_valid !== 1'b0) begin n_fail++;
         $display("FAIL single_c1 level %0d valid %b want 1 0",
                  level, out_valid); end
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      n_chk++; if (out_valid !== 1'b0) begin n_fail++;
         $display("FAIL single_c2_valid got %b want 0", out_valid); end
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      n_chk++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL single_c3 valid %b data %h want 1 a5",
                  out_valid, out_data); end
      n_chk++; if (almost_empty !== 1'b1) begin n_fail++;
         $display("FAIL single_aempty got %b want 1", almost_empty); end
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      n_chk++; if (level !== 11'd0 || out_valid !== 1'b0) begin n_fail++;
         $display("FAIL single_pop level %0d valid %b want 0 0",
                  level, out_valid); end
      n_chk++; if (almost_empty !== 1'b1) begin n_fail++;
         $display("FAIL single_pop_aempty got %b want 1",
                  almost_empty); end
   endtask

   task automatic test_fill();
      int wcnt = 0;
      for (int i = 0; i < 2000 && wcnt < 1026; i++) begin
         tick(1'b1, 8'(wcnt), 1'b0, 1'b0);
         if (last_push) wcnt++;
         n_chk++; if (level !== m_level()) begin n_fail++;
            $display("FAIL fill_level got %0d want %0d",
                     level, m_level()); end
         n_chk++; if (in_ready !== (q.size() < 1026)) begin n_fail++;
            $display("FAIL fill_in_ready got %b at level %0d",
                     in_ready, m_level()); end
         n_chk++; if (almost_full !== (q.size() >= 1000)) begin
            n_fail++;
            $display("FAIL fill_afull got %b at level %0d",
                     almost_full, m_level()); end
         n_chk++; if (almost_empty !== (q.size() <= 4)) begin
            n_fail++;
            $display("FAIL fill_aempty got %b at level %0d",
                     almost_empty, m_level()); end
      end
      n_chk++; if (wcnt != 1026 || level !== 11'd1026) begin n_fail++;
         $display("FAIL fill_count accepted %0d level %0d want 1026",
                  wcnt, level); end
      n_chk++; if (overflow_err !== 1'b0) begin n_fail++;
         $display("FAIL fill_ovf_early got %b want 0", overflow_err); end
      tick(1'b1, 8'hEE, 1'b0, 1'b0);
      n_chk++; if (overflow_err !== 1'b1 || m_ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_ovf got %b want 1", overflow_err); end
      n_chk++; if (level !== 11'd1026 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_hold level %0d ready %b want 1026 0",
                  level, in_ready); end
   endtask

   task automatic test_drain();
      int drn = 0;
      for (int i = 0; i < 1100 && drn < 1026; i++) begin
         n_chk++; if (out_valid !== 1'b1) begin n_fail++;
            $display("FAIL drain_gap at byte %0d valid %b want 1",
                     drn, out_valid); end
         n_chk++; if (out_data !== 8'(drn)) begin n_fail++;
            $display("FAIL drain_data byte %0d got %h want %h",
                     drn, out_data, 8'(drn)); end
         n_chk++; if (level !== 11'(1026 - drn)) begin n_fail++;
            $display("FAIL drain_level got %0d want %0d",
                     level, 1026 - drn); end
         tick(1'b0, 8'h00, 1'b1, 1'b0);
         if (last_pop) drn++;
      end
      n_chk++; if (drn != 1026 || out_valid !== 1'b0) begin n_fail++;
         $display("FAIL drain_end drained %0d valid %b want 1026 0",
                  drn, out_valid); end
      n_chk++; if (level !== 11'd0 || almost_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL drain_empty level %0d aempty %b want 0 1",
                  level, almost_empty); end
   endtask

   task automatic test_stream();
      int sent = 0;
      int rcv = 0;
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      n_chk++; if (overflow_err !== 1'b0 || level !== 11'd0) begin
         n_fail++;
         $display("FAIL stream_flush ovf %b level %0d want 0 0",
                  overflow_err, level); end
      for (int i = 0; i < 5010; i++) begin
         tick(sent < 5000, 8'(sent), 1'b1, 1'b0);
         if (last_push) sent++;
         if (last_pop) rcv++;
         n_chk++; if (out_valid !== m_valid()) begin n_fail++;
            $display("FAIL stream_valid i %0d got %b want %b",
                     i, out_valid, m_valid()); end
         if (m_valid()) begin
            n_chk++; if (out_data !== 8'(rcv)) begin n_fail++;
               $display("FAIL stream_data i %0d got %h want %h",
                        i, out_data, 8'(rcv)); end
         end
         n_chk++; if (level !== m_level()) begin n_fail++;
            $display("FAIL stream_level i %0d got %0d want %0d",
                     i, level, m_level()); end
         if (i >= 2 && i <= 4999) begin
            n_chk++;
            if (level < 11'd2 || level > 11'd3 || out_valid !== 1'b1)
            begin
               n_fail++;
               $display("FAIL stream_steady i %0d level %0d valid %b",
                        i, level, out_valid);
            end
         end
      end
      n_chk++; if (rcv != 5000 || level !== 11'd0) begin n_fail++;
         $display("FAIL stream_end rcv %0d level %0d want 5000 0",
                  rcv, level); end
   endtask

   task automatic test_backpressure();
      bit         pv;
      logic [7:0] pd;
      for (int i = 0; i < 3000; i++) begin
         pv = m_valid();
         pd = pv ? q[0] : 8'h00;
         tick(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              ($urandom_range(0, 99) < 30), 1'b0);
         n_chk++; if (out_valid !== m_valid()) begin n_fail++;
            $display("FAIL bp_valid i %0d got %b want %b",
                     i, out_valid, m_valid()); end
         if (m_valid()) begin
            n_chk++; if (out_data !== q[0]) begin n_fail++;
               $display("FAIL bp_data i %0d got %h want %h",
                        i, out_data, q[0]); end
         end
         if (pv && !last_pop) begin
            n_chk++; if (out_valid !== 1'b1 || out_data !== pd) begin
               n_fail++;
               $display("FAIL bp_stall i %0d got %b %h want 1 %h",
                        i, out_valid, out_data, pd); end
         end
         n_chk++; if (level !== m_level()) begin n_fail++;
            $display("FAIL bp_level i %0d got %0d want %0d",
                     i, level, m_level()); end
         n_chk++; if (almost_empty !== (q.size() <= 4) ||
                      almost_full !== (q.size() >= 1000)) begin
            n_fail++;
            $display("FAIL bp_flags i %0d ae %b af %b level %0d",
                     i, almost_empty, almost_full, m_level()); end
      end
      for (int i = 0; i < 2000 && q.size() > 0; i++) begin
         tick(1'b0, 8'h00, 1'b1, 1'b0);
         n_chk++; if (out_valid !== m_valid() ||
                      (m_valid() && out_data !== q[0])) begin
            n_fail++;
            $display("FAIL bp_drain i %0d valid %b data %h",
                     i, out_valid, out_data); end
      end
      n_chk++; if (level !== 11'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_end level %0d valid %b want 0 0",
                  level, out_valid); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 50; i++) begin
         tick(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      end
      tick(1'b1, 8'h11, 1'b1, 1'b0);
      n_chk++; if (level !== 11'd50) begin n_fail++;
         $display("FAIL flush_pre_level got %0d want 50", level); end
      tick(1'b1, 8'h77, 1'b0, 1'b1);
      n_chk++; if (out_valid !== 1'b0 || level !== 11'd0) begin
         n_fail++;
         $display("FAIL flush_clear valid %b level %0d want 0 0",
                  out_valid, level); end
      n_chk++; if (in_ready !== 1'b1 || almost_empty !== 1'b1 ||
                   almost_full !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_flags rdy %b ae %b af %b want 1 1 0",
                  in_ready, almost_empty, almost_full); end
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      n_chk++; if (out_valid !== 1'b0 || level !== 11'd0) begin
         n_fail++;
         $display("FAIL flush_inflight valid %b level %0d want 0 0",
                  out_valid, level); end
      tick(1'b1, 8'h3C, 1'b0, 1'b0);
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      tick(1'b0, 8'h00, 1'b0, 1'b0);
      n_chk++; if (out_valid !== 1'b1 || out_data !== 8'h3C ||
                   level !== 11'd1) begin
         n_fail++;
         $display("FAIL flush_first valid %b data %h level %0d",
                  out_valid, out_data, level); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_drain();
      test_stream();
      test_backpressure();
      test_flush();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
